ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ADDR_W, default 5, instruction-memory word-address width.
REQ-002 Parameter INSTR_W, default 16, instruction width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hazard stall from decode; holds PC and IF/ID register.
REQ-007 branch_taken  input  1  redirect request from execute.
REQ-008 branch_target  input  ADDR_W  redirect word address.
REQ-009 imem_addr  output  ADDR_W  word address driven to instruction memory; equals PC combinationally.
REQ-010 imem_instr  input  INSTR_W  instruction returned combinationally by instruction memory.
REQ-011 if_instr  output  INSTR_W  registered instruction to decode.
REQ-012 if_pc  output  ADDR_W  registered address of if_instr.
REQ-013 if_pc_plus1  output  ADDR_W  registered if_pc+1, modulo 2^ADDR_W.
REQ-014 if_valid  output  1  if_instr is a real instruction.
REQ-015 halted  output  1  fetch frozen on HALT; driven constant 0 without IFETCH_HALT_EN.

Function
REQ-016 FSM states BOOT, RUN, HALTED; reset SHALL force BOOT.
REQ-017 BOOT: one cycle; IF/ID captures imem_instr at RESET_PC with if_valid=1, PC <= RESET_PC+1; next state RUN. stall and branch_taken SHALL be ignored in BOOT.
REQ-018 RUN, no stall, no branch: IF/ID <= {imem_instr, PC, PC+1}, if_valid<=1, PC <= PC+1.
REQ-019 Fetch latency SHALL be one cycle: instruction at address A appears on if_instr the edge after PC=A is accepted.
REQ-020 PC increment SHALL wrap 2^ADDR_W-1 -> 0 with no flag.
REQ-021 RUN, stall=1, branch_taken=0: PC and all IF/ID outputs SHALL hold.
REQ-022 RUN, branch_taken=1: PC <= branch_target; if_instr <= 0 (NOP), if_valid <= 0; if_pc/if_pc_plus1 hold.
REQ-023 branch_taken SHALL take priority over a simultaneous stall.
REQ-024 Cycle after a branch SHALL fetch branch_target normally (if_valid=1 unless stalled again).
REQ-025 Reset asserted in any state, mid-stall or mid-branch, SHALL override all other inputs on that edge.

Reset
REQ-026 On reset: PC=RESET_PC, if_instr=0, if_pc=0, if_pc_plus1=0, if_valid=0, halted=0, state=BOOT.
REQ-027 imem_addr SHALL equal RESET_PC in the cycle after reset.

Configuration
REQ-028 Macro IFETCH_HALT_EN defined: when RUN captures imem_instr equal to HALT_INSTR, that word SHALL be latched with if_valid=1, PC SHALL not advance, state -> HALTED, halted=1.
REQ-029 In HALTED: PC and IF/ID hold, if_valid<=0 after the first held cycle; branch_taken and stall ignored; exit only by reset.
REQ-030 Macro undefined: HALTED unreachable, HALT_INSTR fetched as an ordinary instruction, halted tied 0.

Structure
REQ-031 Package ifetch_pkg SHALL hold the state enum, NOP_INSTR (16'h0000) and HALT_INSTR (16'hFFFF).
REQ-032 Sub-module ifid_reg (IF/ID pipeline register with load/flush/hold controls) is natural; PC and FSM stay in ifetch.

Verification
REQ-033 Reset, imem holds RAM[a]=16'h1000+a, no stall/branch 4 cycles -> if_instr 16'h1000,1001,1002,1003; if_pc 0..3; if_valid 1.
REQ-034 PC at 31, advance -> if_pc=31, if_pc_plus1=0, imem_addr=0 next cycle.
REQ-035 stall held 3 cycles at PC=5 -> imem_addr=5, if_pc=4 constant throughout; release -> if_pc=5.
REQ-036 branch_taken=1 with stall=1, target=20 -> next cycle if_valid=0, if_instr=0, imem_addr=20; following cycle if_pc=20, if_valid=1.
REQ-037 With IFETCH_HALT_EN, RAM[6]=16'hFFFF -> halted=1, imem_addr frozen at 6, branch_taken=1 to 2 ignored; reset -> halted=0, imem_addr=0.
REQ-038 reset asserted during a branch cycle -> all outputs at REQ-026 values next edge; branch_target not loaded.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the fetch stage.
// FSM state encoding plus the NOP and HALT instruction words.
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  localparam logic [15:0] NOP_INSTR  = 16'h0000;
  localparam logic [15:0] HALT_INSTR = 16'hFFFF;

endpackage

// File: rtl/ifetch_ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
// Controls: load, flush (bubble), drop (clear valid), else hold.
module ifid_reg
  import ifetch_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic               drop,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  pc1,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               if_valid
);

  // Flush keeps the pc fields; only the word and valid are killed.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus1 <= '0;
      if_valid    <= 1'b0;
    end else if (flush) begin
      if_instr <= INSTR_W'(NOP_INSTR);
      if_valid <= 1'b0;
    end else if (load) begin
      if_instr    <= instr;
      if_pc       <= pc;
      if_pc_plus1 <= pc1;
      if_valid    <= 1'b1;
    end else if (drop) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch: PC, fetch FSM and IF/ID register for a one-cycle imem.
// Define IFETCH_HALT_EN to freeze fetch on HALT_INSTR.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               if_valid,
  output logic               halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc1;
  logic              ld;
  logic              fl;
  logic              dr;
  logic              is_halt;

  assign imem_addr = pc;
  assign pc1       = pc + ADDR_W'(1);

`ifdef IFETCH_HALT_EN
  assign is_halt = (imem_instr == INSTR_W'(HALT_INSTR));
`else
  assign is_halt = 1'b0;
`endif

  // IF/ID control decode from the current state and hazards.
  always_comb begin
    ld = 1'b0;
    fl = 1'b0;
    dr = 1'b0;
    unique case (state)
      BOOT:   ld = 1'b1;
      RUN: begin
        if (branch_taken) fl = 1'b1;
        else if (!stall)  ld = 1'b1;
      end
      HALTED: dr = 1'b1;
      default: ;
    endcase
  end

  // Fetch FSM and program counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc    <= ADDR_W'(RESET_PC);
    end else begin
      unique case (state)
        BOOT: begin
          pc    <= pc1;
          state <= RUN;
        end
        RUN: begin
          if (branch_taken) begin
            pc <= branch_target;
          end else if (!stall) begin
            if (is_halt) state <= HALTED;
            else         pc    <= pc1;
          end
        end
        HALTED: ;
        default: state <= BOOT;
      endcase
    end
  end

`ifdef IFETCH_HALT_EN
  // Halt flag rises with the capture of the HALT word.
  always_ff @(posedge clk) begin
    if (reset)
      halted <= 1'b0;
    else if (state == RUN && !branch_taken && !stall && is_halt)
      halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

  ifid_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .flush      (fl),
    .drop       (dr),
    .instr      (imem_instr),
    .pc         (pc),
    .pc1        (pc1),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_plus1(if_pc_plus1),
    .if_valid   (if_valid)
  );

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: scoreboard bench for the fetch stage.
// Expected IF/ID state is pushed per drive, popped after each edge.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [4:0]  branch_target;
  logic [4:0]  imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] if_instr;
  logic [4:0]  if_pc;
  logic [4:0]  if_pc_plus1;
  logic        if_valid;
  logic        halted;

  logic [15:0] ram [32];

`ifdef IFETCH_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  pc;
    logic [4:0]  pc1;
    logic        valid;
    logic        halted;
    logic [4:0]  addr;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [4:0] m_pc;
  logic       m_boot;
  logic       m_halt;

  ifetch #(
    .ADDR_W  (5),
    .INSTR_W (16),
    .RESET_PC(0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pc_plus1  (if_pc_plus1),
    .if_valid     (if_valid),
    .halted       (halted)
  );

  assign imem_instr = ram[imem_addr];

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic s,
                      input logic b, input logic [4:0] t);
    exp_t e;
    @(negedge clk);
    reset = r;
    stall = s;
    branch_taken = b;
    branch_target = t;
    e = last;
    if (r) begin
      e.instr = 16'h0; e.pc = 5'd0; e.pc1 = 5'd0;
      e.valid = 1'b0; e.halted = 1'b0;
      m_pc = 5'd0; m_boot = 1'b1; m_halt = 1'b0;
    end else if (m_halt) begin
      e.valid = 1'b0;
    end else if (!m_boot && b) begin
      e.instr = 16'h0; e.valid = 1'b0;
      m_pc = t;
    end else if (!m_boot && s) begin
      e.valid = last.valid;
    end else begin
      e.instr = ram[m_pc];
      e.pc = m_pc;
      e.pc1 = m_pc + 5'd1;
      e.valid = 1'b1;
      if (HALT_ON && !m_boot && ram[m_pc] == 16'hFFFF) begin
        m_halt = 1'b1;
        e.halted = 1'b1;
      end else begin
        m_pc = m_pc + 5'd1;
      end
      m_boot = 1'b0;
    end
    e.addr = m_pc;
    last = e;
    q.push_back(e);
  endtask

  // Scoreboard pop: compare each pushed expectation after its edge.
  always @(posedge clk) begin : mon
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp += 6;
      if (if_instr !== e.instr) begin
        n_bad++;
        $display("FAIL sb_instr got %h want %h", if_instr, e.instr);
      end
      if (if_pc !== e.pc) begin
        n_bad++;
        $display("FAIL sb_pc got %0d want %0d", if_pc, e.pc);
      end
      if (if_pc_plus1 !== e.pc1) begin
        n_bad++;
        $display("FAIL sb_pc1 got %0d want %0d", if_pc_plus1, e.pc1);
      end
      if (if_valid !== e.valid) begin
        n_bad++;
        $display("FAIL sb_valid got %b want %b", if_valid, e.valid);
      end
      if (halted !== e.halted) begin
        n_bad++;
        $display("FAIL sb_halted got %b want %b", halted, e.halted);
      end
      if (imem_addr !== e.addr) begin
        n_bad++;
        $display("FAIL sb_addr got %0d want %0d", imem_addr, e.addr);
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 5'd0);
    settle();
    n_cmp += 3;
    if (if_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid got %b want 0", if_valid);
    end
    if (if_instr !== 16'h0) begin
      n_bad++; $display("FAIL rst_instr got %h want 0000", if_instr);
    end
    if (imem_addr !== 5'd0) begin
      n_bad++; $display("FAIL rst_addr got %0d want 0", imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 5'd0);
      settle();
      n_cmp += 3;
      if (if_instr !== 16'h1000 + 16'(i)) begin
        n_bad++; $display("FAIL seq_instr got %h want %h", if_instr, 16'h1000 + 16'(i));
      end
      if (if_pc !== 5'(i)) begin
        n_bad++; $display("FAIL seq_pc got %0d want %0d", if_pc, i);
      end
      if (if_valid !== 1'b1) begin
        n_bad++; $display("FAIL seq_valid got %b want 1", if_valid);
      end
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 5'd31);
    step(0, 0, 0, 5'd0);
    settle();
    n_cmp += 3;
    if (if_pc !== 5'd31) begin
      n_bad++; $display("FAIL wrap_pc got %0d want 31", if_pc);
    end
    if (if_pc_plus1 !== 5'd0) begin
      n_bad++; $display("FAIL wrap_pc1 got %0d want 0", if_pc_plus1);
    end
    if (imem_addr !== 5'd0) begin
      n_bad++; $display("FAIL wrap_addr got %0d want 0", imem_addr);
    end
  endtask

  task automatic test_stall();
    step(0, 0, 1, 5'd4);
    step(0, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 5'd0);
      settle();
      n_cmp += 2;
      if (imem_addr !== 5'd5) begin
        n_bad++; $display("FAIL stall_addr got %0d want 5", imem_addr);
      end
      if (if_pc !== 5'd4) begin
        n_bad++; $display("FAIL stall_pc got %0d want 4", if_pc);
      end
    end
    step(0, 0, 0, 5'd0);
    settle();
    n_cmp++;
    if (if_pc !== 5'd5) begin
      n_bad++; $display("FAIL stall_rel got %0d want 5", if_pc);
    end
  endtask

  task automatic test_branch_stall();
    step(0, 1, 1, 5'd20);
    settle();
    n_cmp += 3;
    if (if_valid !== 1'b0) begin
      n_bad++; $display("FAIL br_valid got %b want 0", if_valid);
    end
    if (if_instr !== 16'h0) begin
      n_bad++; $display("FAIL br_instr got %h want 0000", if_instr);
    end
    if (imem_addr !== 5'd20) begin
      n_bad++; $display("FAIL br_addr got %0d want 20", imem_addr);
    end
    step(0, 0, 0, 5'd0);
    settle();
    n_cmp += 2;
    if (if_pc !== 5'd20) begin
      n_bad++; $display("FAIL br_pc got %0d want 20", if_pc);
    end
    if (if_valid !== 1'b1) begin
      n_bad++; $display("FAIL br_valid2 got %b want 1", if_valid);
    end
  endtask

  task automatic test_reset_branch();
    step(0, 0, 0, 5'd0);
    step(1, 1, 1, 5'd9);
    settle();
    n_cmp += 3;
    if (imem_addr !== 5'd0) begin
      n_bad++; $display("FAIL rb_addr got %0d want 0", imem_addr);
    end
    if (if_pc !== 5'd0 || if_pc_plus1 !== 5'd0) begin
      n_bad++; $display("FAIL rb_pc got %0d/%0d want 0/0", if_pc, if_pc_plus1);
    end
    if (if_valid !== 1'b0) begin
      n_bad++; $display("FAIL rb_valid got %b want 0", if_valid);
    end
  endtask

  task automatic test_halt();
    ram[6] = 16'hFFFF;
    step(1, 0, 0, 5'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 5'd0);
    settle();
    n_cmp += 2;
    if (if_instr !== 16'hFFFF) begin
      n_bad++; $display("FAIL halt_instr got %h want ffff", if_instr);
    end
    if (HALT_ON) begin
      if (halted !== 1'b1 || imem_addr !== 5'd6) begin
        n_bad++; $display("FAIL halt_on got h=%b a=%0d want h=1 a=6", halted, imem_addr);
      end
      step(0, 0, 1, 5'd2);
      step(0, 1, 1, 5'd2);
      settle();
      n_cmp += 2;
      if (imem_addr !== 5'd6 || halted !== 1'b1) begin
        n_bad++; $display("FAIL halt_hold got h=%b a=%0d want h=1 a=6", halted, imem_addr);
      end
      if (if_valid !== 1'b0) begin
        n_bad++; $display("FAIL halt_valid got %b want 0", if_valid);
      end
      step(1, 0, 0, 5'd0);
      settle();
      n_cmp++;
      if (halted !== 1'b0 || imem_addr !== 5'd0) begin
        n_bad++; $display("FAIL halt_rst got h=%b a=%0d want h=0 a=0", halted, imem_addr);
      end
    end else begin
      if (halted !== 1'b0 || imem_addr !== 5'd7) begin
        n_bad++; $display("FAIL halt_off got h=%b a=%0d want h=0 a=7", halted, imem_addr);
      end
      step(0, 0, 0, 5'd0);
    end
    ram[6] = 16'h1006;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) ram[a] = 16'h1000 + 16'(a);
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 5'd0;
    last = '{16'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0};
    m_pc = 5'd0;
    m_boot = 1'b1;
    m_halt = 1'b0;
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_branch_stall();
    test_reset_branch();
    test_halt();
    repeat (3) @(posedge clk);
    #5;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL drain got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
